// File: rtl/cassette_recorder_if.sv
// Tape-side bus of the cassette recorder: Q-tick/motor/DAC inputs in,
// SRAM write port and tape status out.
interface cassette_recorder_if;
    logic        Q;
    logic        en;
    logic        rewind;
    logic [5:0]  dac_in;
    logic [15:0] sram_addr;
    logic [7:0]  sram_data;
    logic        sram_wr;
    logic [15:0] byte_count;
    logic        full;

    modport master (
        output Q, en, rewind, dac_in,
        input  sram_addr, sram_data, sram_wr, byte_count, full
    );

    modport slave (
        input  Q, en, rewind, dac_in,
        output sram_addr, sram_data, sram_wr, byte_count, full
    );
endinterface

// File: rtl/cassette_recorder.sv
// Cassette recorder: digitises the DAC output with hysteresis, classifies each
// waveform period as a 1 or 0 bit and writes assembled bytes into tape SRAM.
module cassette_recorder #(
    parameter int unsigned HI_TH     = 36,
    parameter int unsigned LO_TH     = 28,
    parameter int unsigned MIN_P     = 150,
    parameter int unsigned SPLIT     = 560,
    parameter int unsigned MAX_P     = 1200,
    // Last writable SRAM address; reaching it latches full.
    parameter logic [15:0] LAST_ADDR = 16'hFFFF
) (
    input  logic                  clk,
    input  logic                  reset_n,
    cassette_recorder_if.slave    bus
);

    localparam logic [5:0]  L_HI    = 6'(HI_TH);
    localparam logic [5:0]  L_LO    = 6'(LO_TH);
    localparam logic [11:0] L_MIN   = 12'(MIN_P);
    localparam logic [11:0] L_SPLIT = 12'(SPLIT);
    localparam logic [11:0] L_MAX   = 12'(MAX_P);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARM     = 2'd1,
        S_MEASURE = 2'd2
    } state_t;

    state_t      r_state, w_state_nx;
    logic        r_level, w_level_nx, w_rise;
    logic [10:0] r_cnt;
    logic [11:0] w_period;
    logic        w_clr_cnt;
    logic [2:0]  r_bit_idx, w_bit_nx;
    logic [7:0]  r_shift, w_shift_nx;
    logic        w_byte_done;
    logic        r_wr, r_full;
    logic [7:0]  r_data;
    logic [15:0] r_ptr, r_count;

    // Hysteresis comparator on the DAC value.
    always_comb begin
        if (bus.dac_in >= L_HI) begin
            w_level_nx = 1'b1;
        end else if (bus.dac_in < L_LO) begin
            w_level_nx = 1'b0;
        end else begin
            w_level_nx = r_level;
        end
    end

    assign w_rise   = bus.Q & ~r_level & w_level_nx;
    assign w_period = {1'b0, r_cnt} + 12'd1;

    // Digitised level and saturating period counter, advanced on Q ticks.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_level <= 1'b0;
            r_cnt   <= 11'd0;
        end else if (bus.Q) begin
            r_level <= w_level_nx;
            if (w_clr_cnt) begin
                r_cnt <= 11'd0;
            end else if (r_cnt != 11'h7FF) begin
                r_cnt <= r_cnt + 11'd1;
            end
        end
    end

    // Recording state machine, bit classification and byte assembly.
    always_comb begin
        w_state_nx  = r_state;
        w_bit_nx    = r_bit_idx;
        w_shift_nx  = r_shift;
        w_clr_cnt   = w_rise;
        w_byte_done = 1'b0;
        if (bus.rewind) begin
            w_bit_nx   = 3'd0;
            w_shift_nx = 8'd0;
            w_state_nx = bus.en ? S_ARM : S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_bit_nx   = 3'd0;
                    w_shift_nx = 8'd0;
                    w_state_nx = bus.en ? S_ARM : S_IDLE;
                end
                S_ARM: begin
                    if (!bus.en) begin
                        w_state_nx = S_IDLE;
                        w_bit_nx   = 3'd0;
                        w_shift_nx = 8'd0;
                    end else if (w_rise) begin
                        w_state_nx = S_MEASURE;
                    end else begin
                        w_state_nx = S_ARM;
                    end
                end
                S_MEASURE: begin
                    if (!bus.en) begin
                        w_state_nx = S_IDLE;
                        w_bit_nx   = 3'd0;
                        w_shift_nx = 8'd0;
                    end else if (w_rise) begin
                        // Glitches keep counting so they merge into the current cycle.
                        if (w_period < L_MIN) begin
                            w_clr_cnt = 1'b0;
                        end else if (w_period <= L_MAX) begin
                            w_shift_nx  = {(w_period < L_SPLIT), r_shift[7:1]};
                            w_bit_nx    = r_bit_idx + 3'd1;
                            w_byte_done = (r_bit_idx == 3'd7);
                        end else begin
                            w_bit_nx   = 3'd0;
                            w_shift_nx = 8'd0;
                        end
                    end else if (bus.Q && (w_period > L_MAX)) begin
                        w_state_nx = S_ARM;
                        w_bit_nx   = 3'd0;
                        w_shift_nx = 8'd0;
                    end else begin
                        w_state_nx = S_MEASURE;
                    end
                end
                default: begin
                    w_state_nx = S_IDLE;
                    w_bit_nx   = 3'd0;
                    w_shift_nx = 8'd0;
                end
            endcase
        end
    end

    // State, bit index and shift register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'd0;
        end else begin
            r_state   <= w_state_nx;
            r_bit_idx <= w_bit_nx;
            r_shift   <= w_shift_nx;
        end
    end

    // SRAM write strobe, then pointer/count update on the clk after the strobe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr    <= 1'b0;
            r_data  <= 8'd0;
            r_ptr   <= 16'd0;
            r_count <= 16'd0;
            r_full  <= 1'b0;
        end else if (bus.rewind) begin
            r_wr    <= 1'b0;
            r_ptr   <= 16'd0;
            r_count <= 16'd0;
            r_full  <= 1'b0;
        end else begin
            r_wr <= w_byte_done & ~r_full;
            if (w_byte_done && !r_full) begin
                r_data <= w_shift_nx;
            end
            if (r_wr) begin
                if (r_ptr == LAST_ADDR) begin
                    r_full <= 1'b1;
                end else begin
                    r_ptr <= r_ptr + 16'd1;
                end
                if (r_count != 16'hFFFF) begin
                    r_count <= r_count + 16'd1;
                end
            end
        end
    end

    assign bus.sram_addr  = r_ptr;
    assign bus.sram_data  = r_data;
    assign bus.sram_wr    = r_wr;
    assign bus.byte_count = r_count;
    assign bus.full       = r_full;

endmodule

// File: tb/tb_cassette_recorder.sv
// Directed bench for cassette_recorder: a table of byte waveforms followed by
// hand-written glitch, gap, motor-drop, hysteresis, full/rewind and reset cases.
module tb_cassette_recorder;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    cassette_recorder_if bus();

    cassette_recorder #(.LAST_ADDR(16'h0007)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    int q_gap  = 0;
    logic [5:0]  lv_hi = 6'd63;
    logic [5:0]  lv_lo = 6'd0;
    logic [15:0] wa_q[$];
    logic [7:0]  wd_q[$];

    typedef struct {
        int         per[8];
        int         q_gap;
        bit         chain;
        logic [7:0] exp_data;
        int         exp_count;
    } vec_t;
    vec_t vt[4];

    always @(negedge clk) begin
        if (reset_n === 1'b1 && bus.sram_wr === 1'b1) begin
            wa_q.push_back(bus.sram_addr);
            wd_q.push_back(bus.sram_data);
        end
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_wr(string name, int idx, logic [15:0] a, logic [7:0] d);
        if (wa_q.size() > idx) begin
            check({name, "_addr"}, wa_q[idx], a);
            check({name, "_data"}, wd_q[idx], d);
        end else begin
            checks++;
            errors++;
            $display("FAIL %s: strobe %0d missing, got %0d strobes", name, idx, wa_q.size());
        end
    endtask

    task automatic ticks(int n);
        for (int i = 0; i < n; i++) begin
            bus.Q = 1'b1;
            @(posedge clk); #1;
            bus.Q = 1'b0;
            for (int k = 0; k < q_gap; k++) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic cyc(int p);
        bus.dac_in = lv_hi; ticks(p / 2);
        bus.dac_in = lv_lo; ticks(p - p / 2);
    endtask

    // Cycle of length p with a 40-tick spike rising at pre_hi+pre_lo.
    task automatic gcyc(int p, int pre_hi, int pre_lo);
        bus.dac_in = lv_hi; ticks(pre_hi);
        bus.dac_in = lv_lo; ticks(pre_lo);
        bus.dac_in = lv_hi; ticks(40);
        bus.dac_in = lv_lo; ticks(p - pre_hi - pre_lo - 40);
    endtask

    // Closing rise for the last bit, then silence long enough to re-arm.
    task automatic close_gap();
        bus.dac_in = lv_hi; ticks(186);
        bus.dac_in = lv_lo; ticks(1030);
    endtask

    task automatic send_byte(logic [7:0] v);
        for (int i = 0; i < 8; i++) cyc(v[i] ? 373 : 746);
        close_gap();
    endtask

    task automatic check_status(string name, int a, int cnt, logic f);
        check({name, "_addr"}, bus.sram_addr, a);
        check({name, "_count"}, bus.byte_count, cnt);
        check({name, "_full"}, bus.full, f);
    endtask

    initial begin
        vt[0] = '{'{373, 373, 373, 373, 373, 373, 373, 373}, 1, 1'b0, 8'hFF, 1};
        vt[1] = '{'{373, 746, 373, 746, 373, 746, 373, 746}, 0, 1'b1, 8'h55, 2};
        vt[2] = '{'{373, 746, 373, 746, 373, 746, 373, 746}, 0, 1'b0, 8'h55, 3};
        vt[3] = '{'{150, 559, 560, 1200, 373, 746, 373, 746}, 0, 1'b0, 8'h53, 4};

        bus.Q = 1'b0; bus.en = 1'b0; bus.rewind = 1'b0; bus.dac_in = 6'd0;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_wr", bus.sram_wr, 1'b0);
        check("reset_data", bus.sram_data, 8'h00);
        check_status("reset", 0, 0, 1'b0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        bus.en = 1'b1;
        ticks(20);

        // Table-driven bytes: first arm edge comes from the first cycle.
        for (int v = 0; v < 4; v++) begin
            q_gap = vt[v].q_gap;
            for (int b = 0; b < 8; b++) cyc(vt[v].per[b]);
            if (!vt[v].chain) begin
                close_gap();
                check("vec_strobes", wa_q.size(), vt[v].exp_count);
                check_status("vec", vt[v].exp_count, vt[v].exp_count, 1'b0);
            end
            q_gap = 0;
        end
        for (int v = 0; v < 4; v++) check_wr("vec", v, 16'(v), vt[v].exp_data);

        // 0x5A with glitches inside two 0-bit cycles.
        for (int i = 0; i < 8; i++) begin
            if (i == 0)      gcyc(746, 60, 30);
            else if (i == 2) gcyc(700, 60, 85);
            else             cyc((8'h5A >> i) & 1 ? 373 : 746);
        end
        close_gap();
        check_wr("glitch", 4, 16'd4, 8'h5A);
        check("glitch_strobes", wa_q.size(), 5);

        // Three bits, long silence, then a full byte.
        cyc(373); cyc(373); cyc(373);
        bus.dac_in = lv_hi; ticks(186);
        bus.dac_in = lv_lo; ticks(1500);
        send_byte(8'hA3);
        check_wr("gap", 5, 16'd5, 8'hA3);
        check("gap_strobes", wa_q.size(), 6);

        // Motor relay drops after five bits.
        for (int i = 0; i < 5; i++) cyc(373);
        bus.dac_in = lv_hi; ticks(100);
        bus.dac_in = lv_lo; ticks(10);
        bus.en = 1'b0; ticks(10);
        bus.en = 1'b1; ticks(10);
        send_byte(8'h3C);
        check_wr("en_drop", 6, 16'd6, 8'h3C);
        check("en_drop_strobes", wa_q.size(), 7);

        // Hysteresis thresholds: 35 never sets, 28 never clears.
        lv_hi = 6'd35; lv_lo = 6'd0;
        for (int i = 0; i < 4; i++) cyc(373);
        lv_hi = 6'd36; lv_lo = 6'd28;
        for (int i = 0; i < 4; i++) cyc(373);
        check("hyst_no_strobe", wa_q.size(), 7);
        lv_lo = 6'd27;
        bus.dac_in = 6'd27; ticks(5);
        send_byte(8'hC3);
        check_wr("hyst", 7, 16'd7, 8'hC3);
        check_status("full_set", 7, 8, 1'b1);

        // Further bytes are dropped while full.
        lv_hi = 6'd63; lv_lo = 6'd0;
        send_byte(8'hFF);
        check("full_no_strobe", wa_q.size(), 8);
        check_status("full_hold", 7, 8, 1'b1);

        bus.rewind = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_status("rewind", 0, 0, 1'b0);
        bus.rewind = 1'b0;
        ticks(5);
        send_byte(8'hFF);
        check_wr("after_rewind", 8, 16'd0, 8'hFF);
        check_status("after_rewind", 1, 1, 1'b0);

        // Asynchronous reset in the middle of a byte.
        for (int i = 0; i < 4; i++) cyc(373);
        bus.dac_in = lv_hi; ticks(10);
        #2 reset_n = 1'b0;
        #1;
        check("async_wr", bus.sram_wr, 1'b0);
        check("async_data", bus.sram_data, 8'h00);
        check_status("async", 0, 0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("async_strobes", wa_q.size(), 9);
        reset_n = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
